// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 encodings for the SRAM slave.
//   Burst codes (FIXED/INCR/WRAP), response codes (OKAY/SLVERR/DECERR),
//   the only supported beat size (SIZE_4B), channel FSM state types and a
//   helper that merges two response codes into the worse of the two.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B     = 3'd2;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // The codes used here happen to be ordered by severity
  // (OKAY 00 < SLVERR 10 < DECERR 11), so the numerically larger wins.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: combinational per-beat address helper, one per channel.
//   addr      in  ADDR_W  current beat byte address
//   burst     in  2       burst type
//   size      in  3       beat size
//   next_addr out ADDR_W  address of the following beat (FIXED holds, INCR +4)
//   idx       out IDX_W   RAM word index of the current beat
//   resp      out 2       beat response: SLVERR for illegal burst/size,
//                         DECERR when outside the RAM, else OKAY
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int IDX_W  = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        burst,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] next_addr,
  output logic [IDX_W-1:0]  idx,
  output logic [1:0]        resp
);

  logic burst_ok;
  logic in_range;

  always_comb begin
    burst_ok  = 1'b0;
    next_addr = addr;
    case (burst)
      BURST_FIXED: begin
        burst_ok  = 1'b1;
        next_addr = addr;
      end
      BURST_INCR: begin
        burst_ok  = 1'b1;
        next_addr = addr + ADDR_W'(4);
      end
      BURST_WRAP: burst_ok = 1'b0;
      default:    burst_ok = 1'b0;
    endcase
  end

  // Any bit above the RAM's byte range set means the beat lands past the end.
  assign in_range = ((addr >> (IDX_W + 2)) == '0);
  assign idx      = addr[IDX_W+1:2];

  // Illegal burst shape outranks the range check: the whole burst is SLVERR.
  assign resp = (!burst_ok || (size != SIZE_4B)) ? RESP_SLVERR :
                in_range                         ? RESP_OKAY   : RESP_DECERR;

  logic unused_lsb;
  assign unused_lsb = ^addr[1:0];

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave backed by a word-addressed 32-bit RAM.
//   Independent read and write channel FSMs, one outstanding burst each.
//   clk, areset (sync, active-high)
//   AW: s_axi_aw{addr,id,len,size,burst,valid} in, s_axi_awready out
//   W : s_axi_w{data,strb,last,valid} in,         s_axi_wready out
//   B : s_axi_b{id,resp,valid} out,               s_axi_bready in
//   AR: s_axi_ar{addr,id,len,size,burst,valid} in, s_axi_arready out
//   R : s_axi_r{id,data,resp,last,valid} out,     s_axi_rready in
//   Optional macro AXI_SLAVE_STALL_EN: LFSR-driven random deassertion of
//   arready/awready/wready (valid-side outputs are never affected).
//
// state  | meaning
// R_IDLE | arready high, waiting for a read address
// R_DATA | beat on R, waiting for rready; next word prefetched on handshake
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting beats until count reaches len
// W_RESP | bvalid high with worst response of the burst, waiting for bready
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          ADDR_W     = 28,
  parameter int          ID_W       = 4,
  parameter int          MEM_WORDS  = 4096,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              areset,

  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [ID_W-1:0]   s_axi_awid,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,

  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,

  output logic [ID_W-1:0]   s_axi_bid,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,

  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [ID_W-1:0]   s_axi_arid,
  input  logic [7:0]        s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  input  logic [1:0]        s_axi_arburst,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,

  output logic [ID_W-1:0]   s_axi_rid,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- stall
  logic stall;
`ifdef AXI_SLAVE_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (areset) lfsr <= STALL_SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];
`else
  logic [15:0] unused_seed;
  assign unused_seed = STALL_SEED;
  assign stall       = 1'b0;
`endif

  // ------------------------------------------------------- ready / handshakes
  // The ready flops come out of reset already set for IDLE; the areset gate
  // keeps the ports low during reset while letting them rise the moment
  // reset is released.
  logic ar_rdy_q, aw_rdy_q, w_rdy_q;

  assign s_axi_arready = ar_rdy_q & ~areset & ~stall;
  assign s_axi_awready = aw_rdy_q & ~areset & ~stall;
  assign s_axi_wready  = w_rdy_q  & ~areset & ~stall;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
  assign ar_hs = s_axi_arvalid & s_axi_arready;
  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid  & s_axi_wready;
  assign r_hs  = s_axi_rvalid  & s_axi_rready;
  assign b_hs  = s_axi_bvalid  & s_axi_bready;

  // ------------------------------------------------------------ read channel
  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_addr;     // address of the next beat to fetch
  logic [1:0]        r_burst;
  logic [2:0]        r_size;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;

  logic [ADDR_W-1:0] rd_addr_in, rd_next;
  logic [1:0]        rd_burst_in, rd_resp;
  logic [2:0]        rd_size_in;
  logic [IDX_W-1:0]  rd_idx;
  logic [31:0]       rd_word;

  // In IDLE the first beat comes straight from the AR channel so its data
  // can be registered on the handshake itself.
  assign rd_addr_in  = (r_state == R_IDLE) ? s_axi_araddr  : r_addr;
  assign rd_burst_in = (r_state == R_IDLE) ? s_axi_arburst : r_burst;
  assign rd_size_in  = (r_state == R_IDLE) ? s_axi_arsize  : r_size;

  axi_burst_addr #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_rd_addr (
    .addr      (rd_addr_in),
    .burst     (rd_burst_in),
    .size      (rd_size_in),
    .next_addr (rd_next),
    .idx       (rd_idx),
    .resp      (rd_resp)
  );

  assign rd_word = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state      <= R_IDLE;
      ar_rdy_q     <= 1'b1;
      r_addr       <= '0;
      r_burst      <= '0;
      r_size       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
      s_axi_rlast  <= 1'b0;
      s_axi_rvalid <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state      <= R_DATA;
            ar_rdy_q     <= 1'b0;
            r_addr       <= rd_next;
            r_burst      <= s_axi_arburst;
            r_size       <= s_axi_arsize;
            r_len        <= s_axi_arlen;
            r_cnt        <= '0;
            s_axi_rid    <= s_axi_arid;
            s_axi_rdata  <= (rd_resp == RESP_OKAY) ? rd_word : '0;
            s_axi_rresp  <= rd_resp;
            s_axi_rlast  <= (s_axi_arlen == 8'd0);
            s_axi_rvalid <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (s_axi_rlast) begin
              r_state      <= R_IDLE;
              ar_rdy_q     <= 1'b1;
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
            end else begin
              r_addr      <= rd_next;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rdata <= (rd_resp == RESP_OKAY) ? rd_word : '0;
              s_axi_rresp <= rd_resp;
              s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ----------------------------------------------------------- write channel
  wr_state_t         w_state;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_burst;
  logic [2:0]        w_size;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic [1:0]        w_err;      // worst response accumulated so far

  logic [ADDR_W-1:0] wr_next;
  logic [IDX_W-1:0]  wr_idx;
  logic [1:0]        wr_resp;
  logic              w_final;
  logic [1:0]        last_err;
  logic [1:0]        beat_err;
  logic              mem_we;

  axi_burst_addr #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_wr_addr (
    .addr      (w_addr),
    .burst     (w_burst),
    .size      (w_size),
    .next_addr (wr_next),
    .idx       (wr_idx),
    .resp      (wr_resp)
  );

  // Beat count, not wlast, decides where the burst ends; a disagreeing
  // wlast only taints the response.
  assign w_final  = (w_cnt == w_len);
  assign last_err = (s_axi_wlast != w_final) ? RESP_SLVERR : RESP_OKAY;
  assign beat_err = resp_worst(w_err, resp_worst(wr_resp, last_err));
  assign mem_we   = w_hs && (wr_resp == RESP_OKAY);

  always_ff @(posedge clk) begin
    if (areset) begin
      w_state      <= W_IDLE;
      aw_rdy_q     <= 1'b1;
      w_rdy_q      <= 1'b0;
      w_addr       <= '0;
      w_burst      <= '0;
      w_size       <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_err        <= RESP_OKAY;
      s_axi_bid    <= '0;
      s_axi_bresp  <= '0;
      s_axi_bvalid <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_state   <= W_DATA;
            aw_rdy_q  <= 1'b0;
            w_rdy_q   <= 1'b1;
            w_addr    <= s_axi_awaddr;
            w_burst   <= s_axi_awburst;
            w_size    <= s_axi_awsize;
            w_len     <= s_axi_awlen;
            w_cnt     <= '0;
            w_err     <= RESP_OKAY;
            s_axi_bid <= s_axi_awid;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_final) begin
              w_state      <= W_RESP;
              w_rdy_q      <= 1'b0;
              s_axi_bresp  <= beat_err;
              s_axi_bvalid <= 1'b1;
            end else begin
              w_err  <= beat_err;
              w_addr <= wr_next;
              w_cnt  <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (b_hs) begin
            w_state      <= W_IDLE;
            aw_rdy_q     <= 1'b1;
            s_axi_bvalid <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM is deliberately outside reset so contents survive areset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

  localparam int ADDR_W    = 28;
  localparam int ID_W      = 4;
  localparam int MEM_WORDS = 4096;
  localparam int BUDGET    = 200;

  logic              clk = 1'b0;
  logic              areset;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [ID_W-1:0]   awid, arid, bid, rid;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst, bresp, rresp;
  logic              awvalid, awready, wlast, wvalid, wready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic              bvalid, bready, arvalid, arready, rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awid(awid), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arid(arid), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
    logic            chk_data;
  } r_exp_t;

  typedef struct {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  r_exp_t rq[$];
  b_exp_t bq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s got timeout want handshake", name);
  endtask

  // Monitor: samples at negedge; a valid&&ready seen here completes on the next posedge.
  initial begin
    r_exp_t re;
    b_exp_t be;
    forever begin
      @(negedge clk);
      if (!areset) begin
        if (rvalid) chk("arready_low_in_rdata", {31'd0, arready}, 32'd0);
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected got rdata %h want no beat", rdata);
          end else begin
            re = rq.pop_front();
            chk("rid", {28'd0, rid}, {28'd0, re.id});
            chk("rresp", {30'd0, rresp}, {30'd0, re.resp});
            chk("rlast", {31'd0, rlast}, {31'd0, re.last});
            if (re.chk_data) chk("rdata", rdata, re.data);
          end
        end
        if (bvalid && bready) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected got bresp %h want no response", bresp);
          end else begin
            be = bq.pop_front();
            chk("bid", {28'd0, bid}, {28'd0, be.id});
            chk("bresp", {30'd0, bresp}, {30'd0, be.resp});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_aw(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                         input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    awaddr = a; awid = id; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < BUDGET) begin @(negedge clk); n++; end
    if (!awready) timeout_fail("aw_handshake");
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < BUDGET) begin @(negedge clk); n++; end
    if (!wready) timeout_fail("w_handshake");
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                         input logic [7:0] len, input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    araddr = a; arid = id; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < BUDGET) begin @(negedge clk); n++; end
    if (!arready) timeout_fail("ar_handshake");
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic exp_r(input logic [ID_W-1:0] id, input logic [31:0] d, input logic [1:0] resp,
                       input logic last, input logic cd);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last; e.chk_data = cd;
    rq.push_back(e);
  endtask

  task automatic exp_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    bq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < BUDGET) begin @(negedge clk); n++; end
    if (rq.size() != 0 || bq.size() != 0) begin
      timeout_fail("drain");
      rq.delete(); bq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic write1(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                        input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp);
    exp_b(id, resp);
    send_aw(a, id, 8'd0, 2'b01, 3'd2);
    send_w(d, s, 1'b1);
    drain();
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;

    // Reset: every output low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {arready, awready, wready, rvalid, bvalid, rlast, bresp, rresp},
        32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1 areset = 1'b0;
    @(negedge clk);
    chk("awready_after_rst", {31'd0, awready}, 32'd1);
    chk("arready_after_rst", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;

    // Single write/read.
    write1(28'h10, 4'h3, 32'hDEADBEEF, 4'hF, 2'b00);
    exp_r(4'h5, 32'hDEADBEEF, 2'b00, 1'b1, 1'b1);
    send_ar(28'h10, 4'h5, 8'd0, 2'b01, 3'd2);
    drain();

    // INCR len3 write then read back.
    exp_b(4'h1, 2'b00);
    send_aw(28'h100, 4'h1, 8'd3, 2'b01, 3'd2);
    for (int i = 1; i <= 4; i++) send_w(i, 4'hF, i == 4);
    drain();
    for (int i = 1; i <= 4; i++) exp_r(4'h2, i, 2'b00, i == 4, 1'b1);
    send_ar(28'h100, 4'h2, 8'd3, 2'b01, 3'd2);
    drain();

    // Byte strobes.
    write1(28'h200, 4'h6, 32'hFFFFFFFF, 4'hF, 2'b00);
    write1(28'h200, 4'h6, 32'h00000000, 4'b0101, 2'b00);
    exp_r(4'h6, 32'hFF00FF00, 2'b00, 1'b1, 1'b1);
    send_ar(28'h200, 4'h6, 8'd0, 2'b01, 3'd2);
    drain();

    // FIXED burst hits the same word twice.
    exp_b(4'hA, 2'b00);
    send_aw(28'h600, 4'hA, 8'd1, 2'b00, 3'd2);
    send_w(32'h11, 4'hF, 1'b0);
    send_w(32'h22, 4'hF, 1'b1);
    drain();
    exp_r(4'hA, 32'h22, 2'b00, 1'b1, 1'b1);
    send_ar(28'h600, 4'hA, 8'd0, 2'b01, 3'd2);
    drain();

    // Range boundary: last word ok, one past end DECERR.
    write1(28'h3FFC, 4'h1, 32'hCAFEF00D, 4'hF, 2'b00);
    write1(MEM_WORDS * 4, 4'h2, 32'h12345678, 4'hF, 2'b11);
    exp_r(4'h3, 32'h0, 2'b11, 1'b1, 1'b1);
    send_ar(MEM_WORDS * 4, 4'h3, 8'd0, 2'b01, 3'd2);
    drain();
    exp_r(4'h4, 32'hCAFEF00D, 2'b00, 1'b0, 1'b1);
    exp_r(4'h4, 32'h0, 2'b11, 1'b1, 1'b1);
    send_ar(28'h3FFC, 4'h4, 8'd1, 2'b01, 3'd2);
    drain();

    // Illegal size / burst -> SLVERR, no RAM effect.
    exp_b(4'h4, 2'b10);
    send_aw(28'h10, 4'h4, 8'd0, 2'b01, 3'd0);
    send_w(32'h12345678, 4'hF, 1'b1);
    drain();
    exp_r(4'h7, 32'h0, 2'b10, 1'b1, 1'b0);
    send_ar(28'h10, 4'h7, 8'd0, 2'b01, 3'd0);
    drain();
    exp_r(4'h8, 32'h0, 2'b10, 1'b0, 1'b0);
    exp_r(4'h8, 32'h0, 2'b10, 1'b1, 1'b0);
    send_ar(28'h10, 4'h8, 8'd1, 2'b10, 3'd2);
    drain();
    exp_r(4'h5, 32'hDEADBEEF, 2'b00, 1'b1, 1'b1);
    send_ar(28'h10, 4'h5, 8'd0, 2'b01, 3'd2);
    drain();

    // rready stall mid-burst: beat 2 must stay put.
    exp_b(4'hB, 2'b00);
    send_aw(28'h300, 4'hB, 8'd3, 2'b01, 3'd2);
    for (int i = 0; i < 4; i++) send_w(32'hA0 + i, 4'hF, i == 3);
    drain();
    for (int i = 0; i < 4; i++) exp_r(4'hC, 32'hA0 + i, 2'b00, i == 3, 1'b1);
    rready = 1'b0;
    send_ar(28'h300, 4'hC, 8'd3, 2'b01, 3'd2);
    begin
      int n = 0;
      while (!rvalid && n < BUDGET) begin @(negedge clk); n++; end
      if (!rvalid) timeout_fail("rvalid_rise");
    end
    @(posedge clk); #1 rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rvalid", {31'd0, rvalid}, 32'd1);
      chk("stall_rdata", rdata, 32'hA1);
      chk("stall_rlast", {31'd0, rlast}, 32'd0);
    end
    @(posedge clk); #1 rready = 1'b1;
    drain();

    // Early wlast -> SLVERR, length still from awlen.
    exp_b(4'h9, 2'b10);
    send_aw(28'h400, 4'h9, 8'd3, 2'b01, 3'd2);
    send_w(32'h1, 4'hF, 1'b0);
    send_w(32'h2, 4'hF, 1'b1);
    send_w(32'h3, 4'hF, 1'b0);
    send_w(32'h4, 4'hF, 1'b1);
    drain();

    // Reset mid write burst: no response, RAM kept.
    send_aw(28'h500, 4'h7, 8'd3, 2'b01, 3'd2);
    send_w(32'h55, 4'hF, 1'b0);
    send_w(32'h66, 4'hF, 1'b0);
    areset = 1'b1;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    chk("awready_after_midburst_rst", {31'd0, awready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("bvalid_after_rst", {31'd0, bvalid}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    exp_r(4'h1, 32'h1, 2'b00, 1'b1, 1'b1);
    send_ar(28'h100, 4'h1, 8'd0, 2'b01, 3'd2);
    drain();
    exp_r(4'h2, 32'h55, 2'b00, 1'b0, 1'b1);
    exp_r(4'h2, 32'h66, 2'b00, 1'b1, 1'b1);
    send_ar(28'h500, 4'h2, 8'd1, 2'b01, 3'd2);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
